// File: rtl/jtag_dtm_pkg.sv
// Shared definitions for the JTAG debug transport module: instruction codes,
// DMI op/status codes, DTMCS field layout and TAP state encodings.
package jtag_dtm_pkg;

    // Instruction register codes
    localparam logic [4:0] IR_IDCODE      = 5'h01;
    localparam logic [4:0] IR_DTMCS       = 5'h10;
    localparam logic [4:0] IR_DMI         = 5'h11;
    localparam logic [4:0] IR_RESET_VAL   = 5'h01;
    localparam logic [4:0] IR_CAPTURE_VAL = 5'b00001;

    // DMI op field (request) and sticky status codes
    localparam logic [1:0] DMI_OP_READ    = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE   = 2'd2;
    localparam logic [1:0] DMI_STAT_OK    = 2'd0;
    localparam logic [1:0] DMI_STAT_BUSY  = 2'd3;

    // DTMCS field ranges
    localparam int DTMCS_VERSION_LSB = 0;
    localparam int DTMCS_VERSION_MSB = 3;
    localparam int DTMCS_ABITS_LSB   = 4;
    localparam int DTMCS_ABITS_MSB   = 9;
    localparam int DTMCS_STAT_LSB    = 10;
    localparam int DTMCS_STAT_MSB    = 11;
    localparam int DTMCS_IDLE_LSB    = 12;
    localparam int DTMCS_IDLE_MSB    = 14;
    localparam int DTMCS_DMIRESET    = 16;

    localparam logic [3:0] DTMCS_VERSION = 4'd1;
    localparam logic [2:0] DTMCS_IDLE    = 3'd1;

    // IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        TAP_TLR        = 4'h0,
        TAP_RTI        = 4'h1,
        TAP_SEL_DR     = 4'h2,
        TAP_CAPTURE_DR = 4'h3,
        TAP_SHIFT_DR   = 4'h4,
        TAP_EXIT1_DR   = 4'h5,
        TAP_PAUSE_DR   = 4'h6,
        TAP_EXIT2_DR   = 4'h7,
        TAP_UPDATE_DR  = 4'h8,
        TAP_SEL_IR     = 4'h9,
        TAP_CAPTURE_IR = 4'hA,
        TAP_SHIFT_IR   = 4'hB,
        TAP_EXIT1_IR   = 4'hC,
        TAP_PAUSE_IR   = 4'hD,
        TAP_EXIT2_IR   = 4'hE,
        TAP_UPDATE_IR  = 4'hF
    } tap_state_e;

    // Data register selected by the committed instruction
    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_DTMCS  = 2'd2,
        DR_DMI    = 2'd3
    } dr_sel_e;

    function automatic dr_sel_e decode_ir(input logic [4:0] ir);
        case (ir)
            IR_IDCODE: return DR_IDCODE;
            IR_DTMCS:  return DR_DTMCS;
            IR_DMI:    return DR_DMI;
            default:   return DR_BYPASS;
        endcase
    endfunction

    function automatic logic [31:0] dtmcs_word(input logic [1:0] stat, input int abits);
        logic [31:0] w;
        w = '0;
        w[DTMCS_VERSION_MSB:DTMCS_VERSION_LSB] = DTMCS_VERSION;
        w[DTMCS_ABITS_MSB:DTMCS_ABITS_LSB]     = 6'(abits);
        w[DTMCS_STAT_MSB:DTMCS_STAT_LSB]       = stat;
        w[DTMCS_IDLE_MSB:DTMCS_IDLE_LSB]       = DTMCS_IDLE;
        return w;
    endfunction

endpackage

// File: rtl/jtag_dtm_if.sv
// DMI request/response bus between the DTM (master) and the debug module (slave).
interface jtag_dtm_if #(
    parameter int ABITS = 7
);
    logic             valid;
    logic             ready;
    logic             write;
    logic [ABITS-1:0] addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;

    modport master (output valid, write, addr, wdata, input  ready, rdata);
    modport slave  (input  valid, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller plus instruction register, stepped by the
// oversampled tck rising-edge pulse.
module jtag_tap
    import jtag_dtm_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       tck_rise,
    input  logic       tms,
    input  logic       tdi,
    output tap_state_e state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic [4:0] ir,
    output logic       ir_tdo
);

    tap_state_e state_q, state_d;
    logic [4:0] ir_q, ir_d;
    logic [4:0] ir_sr_q, ir_sr_d;

    // State, committed IR and IR shift register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= TAP_TLR;
            ir_q    <= IR_RESET_VAL;
            ir_sr_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ir_sr_q <= ir_sr_d;
        end
    end

    // Next-state transitions and per-state action strobes
    always_comb begin
        state_d    = state_q;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        if (tck_rise) begin
            capture_dr = (state_q == TAP_CAPTURE_DR);
            shift_dr   = (state_q == TAP_SHIFT_DR);
            update_dr  = (state_q == TAP_UPDATE_DR);
            capture_ir = (state_q == TAP_CAPTURE_IR);
            shift_ir   = (state_q == TAP_SHIFT_IR);
            update_ir  = (state_q == TAP_UPDATE_IR);
            case (state_q)
                TAP_TLR:        state_d = tms ? TAP_TLR      : TAP_RTI;
                TAP_RTI:        state_d = tms ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:     state_d = tms ? TAP_SEL_IR   : TAP_CAPTURE_DR;
                TAP_CAPTURE_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
                TAP_PAUSE_DR:   state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
                TAP_UPDATE_DR:  state_d = tms ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:     state_d = tms ? TAP_TLR      : TAP_CAPTURE_IR;
                TAP_CAPTURE_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
                TAP_PAUSE_IR:   state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
                TAP_UPDATE_IR:  state_d = tms ? TAP_SEL_DR   : TAP_RTI;
                default:        state_d = TAP_TLR;
            endcase
        end
    end

    // IR capture/shift and commit; Test-Logic-Reset forces IDCODE
    always_comb begin
        ir_sr_d = ir_sr_q;
        ir_d    = ir_q;
        if (capture_ir) begin
            ir_sr_d = IR_CAPTURE_VAL;
        end else if (shift_ir) begin
            ir_sr_d = {tdi, ir_sr_q[4:1]};
        end
        if (state_q == TAP_TLR) begin
            ir_d = IR_RESET_VAL;
        end else if (update_ir) begin
            ir_d = ir_sr_q;
        end
    end

    assign state  = state_q;
    assign ir     = ir_q;
    assign ir_tdo = ir_sr_q[0];

endmodule

// File: rtl/jtag_dtm.sv
// JTAG debug transport module: oversamples the JTAG pins on clk, runs the TAP,
// and turns DMI scans into DMI bus requests with sticky busy status.
module jtag_dtm
    import jtag_dtm_pkg::*;
#(
    parameter logic [31:0] IDCODE = 32'h0000_0001,
    parameter int          ABITS  = 7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    jtag_dtm_if.master dmi
);

    localparam int DRW = ABITS + 34;

    logic [2:0]       tck_sync_q, tck_sync_d;
    logic [1:0]       tms_sync_q, tms_sync_d;
    logic [1:0]       tdi_sync_q, tdi_sync_d;
    logic             tck_rise, tck_fall, tms_s, tdi_s;

    tap_state_e       tap_state;
    logic             capture_dr, shift_dr, update_dr;
    logic             capture_ir, shift_ir, update_ir;
    logic [4:0]       ir;
    logic             ir_tdo;
    dr_sel_e          dr_sel;

    logic [DRW-1:0]   dr_q, dr_d;
    logic             tdo_q, tdo_d;
    logic             valid_q, valid_d;
    logic             write_q, write_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       status_q, status_d;

    logic             xfer, busy;
    logic [1:0]       upd_op;
    logic [31:0]      upd_data;
    logic [ABITS-1:0] upd_addr;

    // The IR strobes are consumed inside the TAP; collected here so the
    // exported strobes are not flagged as dangling.
    logic unused_ir_strobes;
    assign unused_ir_strobes = ^{capture_ir, shift_ir, update_ir};

    // Synchronizer shift: two stages per pin, plus a third tck stage for edge detection
    always_comb begin
        tck_sync_d = {tck_sync_q[1:0], tck};
        tms_sync_d = {tms_sync_q[0], tms};
        tdi_sync_d = {tdi_sync_q[0], tdi};
    end

    assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
    assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];

    jtag_tap u_tap (
        .clk        (clk),
        .resetn     (resetn),
        .tck_rise   (tck_rise),
        .tms        (tms_s),
        .tdi        (tdi_s),
        .state      (tap_state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .ir         (ir),
        .ir_tdo     (ir_tdo)
    );

    assign dr_sel   = decode_ir(ir);
    assign xfer     = valid_q & dmi.ready;
    // A transfer in this cycle retires the request before a new scan is judged
    assign busy     = valid_q & ~dmi.ready;
    assign upd_op   = dr_q[1:0];
    assign upd_data = dr_q[33:2];
    assign upd_addr = dr_q[DRW-1:34];

    // All state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            dr_q       <= '0;
            tdo_q      <= 1'b0;
            valid_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= DMI_STAT_OK;
        end else begin
            tck_sync_q <= tck_sync_d;
            tms_sync_q <= tms_sync_d;
            tdi_sync_q <= tdi_sync_d;
            dr_q       <= dr_d;
            tdo_q      <= tdo_d;
            valid_q    <= valid_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
        end
    end

    // Data register capture and LSB-first shift; length depends on the instruction
    always_comb begin
        dr_d = dr_q;
        if (capture_dr) begin
            case (dr_sel)
                DR_IDCODE: dr_d = DRW'(IDCODE);
                DR_DTMCS:  dr_d = DRW'(dtmcs_word(status_q, ABITS));
                DR_DMI:    dr_d = {addr_q, rdata_q, (busy ? DMI_STAT_BUSY : status_q)};
                default:   dr_d = '0;
            endcase
        end else if (shift_dr) begin
            case (dr_sel)
                DR_IDCODE, DR_DTMCS: dr_d = DRW'({tdi_s, dr_q[31:1]});
                DR_DMI:              dr_d = {tdi_s, dr_q[DRW-1:1]};
                default:             dr_d = DRW'(tdi_s);
            endcase
        end
    end

    // tdo changes on tck falling edges only; quiet outside the shift states
    always_comb begin
        tdo_d = tdo_q;
        if (tck_fall) begin
            if (tap_state == TAP_SHIFT_IR) begin
                tdo_d = ir_tdo;
            end else if (tap_state == TAP_SHIFT_DR) begin
                tdo_d = dr_q[0];
            end else begin
                tdo_d = 1'b0;
            end
        end
    end

    // DMI request tracking: retire on transfer, then accept or reject new scans
    always_comb begin
        valid_d  = valid_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        if (xfer) begin
            valid_d = 1'b0;
            if (!write_q) begin
                rdata_d = dmi.rdata;
            end
        end
        if (capture_dr && dr_sel == DR_DMI && busy) begin
            status_d = DMI_STAT_BUSY;
        end
        if (update_dr) begin
            if (dr_sel == DR_DTMCS) begin
                if (dr_q[DTMCS_DMIRESET]) begin
                    status_d = DMI_STAT_OK;
                end
            end else if (dr_sel == DR_DMI) begin
                if (busy) begin
                    status_d = DMI_STAT_BUSY;
                end else if (status_q == DMI_STAT_OK &&
                             (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE)) begin
                    valid_d = 1'b1;
                    write_d = (upd_op == DMI_OP_WRITE);
                    addr_d  = upd_addr;
                    wdata_d = upd_data;
                end
            end
        end
    end

    assign tdo       = tdo_q;
    assign dmi.valid = valid_q;
    assign dmi.write = write_q;
    assign dmi.addr  = addr_q;
    assign dmi.wdata = wdata_q;

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: table of single-register scans, then hand-written
// DMI write/read, busy/dmireset and reset-abort sequences.
module tb_jtag_dtm;
    import jtag_dtm_pkg::*;

    localparam int ABITS = 7;
    localparam int DRW   = ABITS + 34;
    localparam int HALF  = 8;   // clk cycles per tck half period
    localparam int NV    = 7;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic tck    = 1'b0;
    logic tms    = 1'b0;
    logic tdi    = 1'b0;
    logic tdo;

    jtag_dtm_if #(.ABITS(ABITS)) dmi_bus ();

    jtag_dtm #(.IDCODE(32'h0000_0001), .ABITS(ABITS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .tck    (tck),
        .tms    (tms),
        .tdi    (tdi),
        .tdo    (tdo),
        .dmi    (dmi_bus)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int errors     = 0;
    int xfer_count = 0;

    always @(posedge clk) begin
        if (resetn && dmi_bus.valid === 1'b1 && dmi_bus.ready === 1'b1) xfer_count++;
    end

    typedef struct {
        string       name;
        logic [4:0]  ir;
        int          nbits;
        logic [63:0] din;
        logic [63:0] exp_dout;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return (64'(a) << 34) | (64'(d) << 2) | 64'(op);
    endfunction

    // One tck period: fall (DUT updates tdo), sample tdo, rise (DUT samples tms/tdi)
    task automatic jtag_clk(input logic tms_v, input logic tdi_v, output logic tdo_v);
        @(negedge clk);
        tms = tms_v;
        tdi = tdi_v;
        tck = 1'b0;
        repeat (HALF) @(negedge clk);
        tdo_v = tdo;
        tck = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tap_reset();
        logic b;
        for (int i = 0; i < 5; i++) jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
    endtask

    // From Run-Test/Idle, scan a new IR and return to Run-Test/Idle
    task automatic shift_ir(input logic [4:0] v, output logic [4:0] cap);
        logic b;
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            jtag_clk(i == 4, v[i], b);
            cap[i] = b;
        end
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
    endtask

    // From Run-Test/Idle, scan n DR bits and return to Run-Test/Idle
    task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic b;
        dout = '0;
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            jtag_clk(i == n - 1, din[i], b);
            dout[i] = b;
        end
        jtag_clk(1'b1, 1'b0, b);
        jtag_clk(1'b0, 1'b0, b);
    endtask

    task automatic ready_pulse();
        @(negedge clk);
        dmi_bus.ready = 1'b1;
        @(negedge clk);
        dmi_bus.ready = 1'b0;
    endtask

    initial begin
        logic [4:0]  cap;
        logic [63:0] dout;

        dmi_bus.ready = 1'b0;
        dmi_bus.rdata = '0;

        vecs[0] = '{"idcode",        IR_IDCODE, 32, 64'h0,        64'h0000_0001,   1'b0};
        vecs[1] = '{"dtmcs",         IR_DTMCS,  32, 64'h0,        64'h0000_1071,   1'b0};
        vecs[2] = '{"bypass_1f",     5'h1F,      2, 64'h3,        64'h2,           1'b0};
        vecs[3] = '{"bypass_12",     5'h12,      2, 64'h1,        64'h2,           1'b0};
        vecs[4] = '{"idcode_tdi_msb", IR_IDCODE, 33, 64'h1,       64'h1_0000_0001, 1'b0};
        vecs[5] = '{"dmi_op3",       IR_DMI,   DRW, dmi_word(7'h09, 32'hA5, 2'd3), 64'h0, 1'b0};
        vecs[6] = '{"dmi_op0",       IR_DMI,   DRW, dmi_word(7'h09, 32'h0,  2'd0), 64'h0, 1'b0};

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_tdo",   64'(tdo), 64'h0);
        chk("rst_valid", 64'(dmi_bus.valid), 64'h0);
        chk("rst_write", 64'(dmi_bus.write), 64'h0);
        chk("rst_addr",  64'(dmi_bus.addr),  64'h0);
        chk("rst_wdata", 64'(dmi_bus.wdata), 64'h0);
        chk("rst_tap",   64'(dut.u_tap.state_q), 64'(TAP_TLR));
        chk("rst_ir",    64'(dut.u_tap.ir_q), 64'h01);
        $display("reset checked");
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        tap_reset();

        // Table-driven single-register scans
        for (int i = 0; i < NV; i++) begin
            shift_ir(vecs[i].ir, cap);
            chk({vecs[i].name, "_ircap"}, 64'(cap), 64'h01);
            shift_dr(vecs[i].din, vecs[i].nbits, dout);
            chk(vecs[i].name, dout, vecs[i].exp_dout);
            chk({vecs[i].name, "_valid"}, 64'(dmi_bus.valid), 64'(vecs[i].exp_valid));
            $display("vec %0d %s ir=%h dout=%h", i, vecs[i].name, vecs[i].ir, dout);
        end

        // DMI write held until ready
        shift_ir(IR_DMI, cap);
        shift_dr(dmi_word(7'h04, 32'hDEADBEEF, 2'd2), DRW, dout);
        chk("wr_capture", dout, 64'h0);
        chk("wr_valid", 64'(dmi_bus.valid), 64'h1);
        chk("wr_write", 64'(dmi_bus.write), 64'h1);
        chk("wr_addr",  64'(dmi_bus.addr),  64'h04);
        chk("wr_wdata", 64'(dmi_bus.wdata), 64'hDEADBEEF);
        repeat (20) @(negedge clk);
        chk("wr_hold_valid", 64'(dmi_bus.valid), 64'h1);
        chk("wr_hold_addr",  64'(dmi_bus.addr),  64'h04);
        chk("wr_hold_wdata", 64'(dmi_bus.wdata), 64'hDEADBEEF);
        ready_pulse();
        chk("wr_done_valid", 64'(dmi_bus.valid), 64'h0);
        chk("wr_xfers", 64'(xfer_count), 64'd1);
        $display("dmi write addr=04 data=deadbeef");

        // DMI read, then capture shows returned data with op=0
        shift_dr(dmi_word(7'h04, 32'h0, 2'd1), DRW, dout);
        chk("rd_capture", dout, dmi_word(7'h04, 32'h0, 2'd0));
        chk("rd_valid", 64'(dmi_bus.valid), 64'h1);
        chk("rd_write", 64'(dmi_bus.write), 64'h0);
        dmi_bus.rdata = 32'hDEADBEEF;
        ready_pulse();
        dmi_bus.rdata = '0;
        chk("rd_xfers", 64'(xfer_count), 64'd2);
        shift_dr(dmi_word(7'h00, 32'h0, 2'd0), DRW, dout);
        chk("rd_result", dout, dmi_word(7'h04, 32'hDEADBEEF, 2'd0));
        chk("rd_nop_valid", 64'(dmi_bus.valid), 64'h0);
        $display("dmi read addr=04 data=%h", dout[33:2]);

        // Second update while the responder stalls -> busy, no second request
        shift_dr(dmi_word(7'h05, 32'h12345678, 2'd2), DRW, dout);
        chk("busy_first_capture", dout, dmi_word(7'h04, 32'hDEADBEEF, 2'd0));
        chk("busy_first_valid", 64'(dmi_bus.valid), 64'h1);
        shift_dr(dmi_word(7'h06, 32'h0, 2'd1), DRW, dout);
        chk("busy_addr",  64'(dmi_bus.addr),  64'h05);
        chk("busy_write", 64'(dmi_bus.write), 64'h1);
        chk("busy_wdata", 64'(dmi_bus.wdata), 64'h12345678);
        ready_pulse();
        chk("busy_xfers", 64'(xfer_count), 64'd3);
        chk("busy_done_valid", 64'(dmi_bus.valid), 64'h0);
        // Status stays busy after the transfer; a read is refused
        shift_dr(dmi_word(7'h08, 32'h0, 2'd1), DRW, dout);
        chk("busy_sticky", dout, dmi_word(7'h05, 32'hDEADBEEF, 2'd3));
        chk("busy_refused_valid", 64'(dmi_bus.valid), 64'h0);
        chk("busy_refused_addr",  64'(dmi_bus.addr),  64'h05);
        $display("dmi busy status=%0d", dout[1:0]);

        // dmireset clears the sticky status
        shift_ir(IR_DTMCS, cap);
        shift_dr(64'h0001_0000, 32, dout);
        chk("dtmcs_busy", dout, 64'h0000_1C71);
        shift_dr(64'h0, 32, dout);
        chk("dtmcs_cleared", dout, 64'h0000_1071);
        shift_ir(IR_DMI, cap);
        shift_dr(dmi_word(7'h07, 32'h0, 2'd1), DRW, dout);
        chk("clr_capture", dout, dmi_word(7'h05, 32'hDEADBEEF, 2'd0));
        chk("clr_valid", 64'(dmi_bus.valid), 64'h1);
        chk("clr_addr",  64'(dmi_bus.addr),  64'h07);
        chk("clr_write", 64'(dmi_bus.write), 64'h0);
        $display("dmireset done, read addr=07 issued");

        // Reset while a request is outstanding
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst2_valid", 64'(dmi_bus.valid), 64'h0);
        chk("rst2_tap",   64'(dut.u_tap.state_q), 64'(TAP_TLR));
        chk("rst2_ir",    64'(dut.u_tap.ir_q), 64'h01);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst2_no_retry", 64'(dmi_bus.valid), 64'h0);
        chk("rst2_xfers", 64'(xfer_count), 64'd3);
        begin
            logic b;
            jtag_clk(1'b0, 1'b0, b);
        end
        shift_dr(64'h0, 32, dout);
        chk("rst2_idcode", dout, 64'h0000_0001);
        $display("reset during request done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_dtm.md
JTAG_DTM -- requirements
Module: jtag_dtm

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h0000_0001, value shifted out by the IDCODE instruction.
REQ-002 SHALL have parameter ABITS, default 7, the DMI address width.
REQ-003 clk  input  1  system clock; all logic rising-edge on clk.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 tck  input  1  JTAG test clock, asynchronous to clk, oversampled.
REQ-006 tms  input  1  JTAG mode select.
REQ-007 tdi  input  1  JTAG serial data in.
REQ-008 tdo  output  1  JTAG serial data out, registered.
REQ-009 dmi_valid  output  1  DMI request valid.
REQ-010 dmi_ready  input  1  DMI responder ready; transfer occurs when dmi_valid && dmi_ready.
REQ-011 dmi_write  output  1  1 = write, 0 = read.
REQ-012 dmi_addr  output  ABITS  DMI register address.
REQ-013 dmi_wdata  output  32  DMI write data.
REQ-014 dmi_rdata  input  32  DMI read data, valid in the transfer cycle.

Function
REQ-015 SHALL pass tck, tms and tdi through 2-flop synchronizers; tck_rise/tck_fall = single-clk pulses on synchronized 0->1 / 1->0 transitions.
REQ-016 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advanced only on tck_rise using synchronized tms.
REQ-017 Five consecutive tck_rise with tms=1 SHALL reach Test-Logic-Reset from any state.
REQ-018 Test-Logic-Reset SHALL load IR with 5'h01.
REQ-019 IR SHALL be 5 bits; Capture-IR loads 5'b00001; Update-IR commits.
REQ-020 Decoded IR values: 0x01 IDCODE (32b), 0x10 DTMCS (32b), 0x11 DMI (ABITS+34b); all others BYPASS (1b, captures 0).
REQ-021 Shift-IR/Shift-DR SHALL shift LSB-first on tck_rise, tdi entering at MSB.
REQ-022 tdo SHALL be updated on tck_fall to bit0 of the active shift register; tdo = 0 outside Shift states.
REQ-023 DTMCS capture: version[3:0]=1, abits[9:4]=ABITS, dmistat[11:10]=sticky status, idle[14:12]=1, other bits 0.
REQ-024 DTMCS Update-DR with bit16 (dmireset)=1 SHALL clear sticky status to 0; all other written bits ignored.
REQ-025 DMI scan layout: op[1:0], data[33:2], addr[ABITS+33:34].
REQ-026 DMI Capture-DR SHALL load {dmi_addr, last read data, op=sticky status}.
REQ-027 DMI Update-DR with op=1 (read) or op=2 (write), transaction idle and status 0 SHALL latch addr/data/write and assert dmi_valid on the next clk.
REQ-028 DMI Update-DR with op=0 or op=3 SHALL start nothing.
REQ-029 DMI Update-DR while a transaction is outstanding SHALL set sticky status to 3 (busy) and start nothing.
REQ-030 DMI Update-DR while status is nonzero SHALL start nothing.
REQ-031 dmi_valid, dmi_write, dmi_addr and dmi_wdata SHALL stay stable until the clk cycle where dmi_ready=1.
REQ-032 dmi_valid SHALL deassert on the clk after the transfer.
REQ-033 A read transfer SHALL capture dmi_rdata into the last-read-data register in the transfer cycle.
REQ-034 After the transfer, the transaction SHALL be idle; sticky status SHALL be unchanged.
REQ-035 Capture-DR of DMI during an outstanding transaction SHALL set sticky status to 3.
REQ-036 Simultaneous transfer and Update-DR in the same clk: the transfer completes first, then the new op is accepted.

Reset
REQ-037 resetn=0 SHALL clear to 0: synchronizers, tdo, dmi_valid, dmi_write, dmi_addr, dmi_wdata, last-read-data, sticky status.
REQ-038 resetn=0 SHALL set TAP state = Test-Logic-Reset and IR = 5'h01.
REQ-039 Reset during an outstanding transaction SHALL drop dmi_valid on the next clk with no retry.

Structure
REQ-040 The shared header SHALL hold: IR codes, DMI op/status codes, DTMCS field ranges, TAP state encodings.
REQ-041 The TAP FSM and IR SHALL live in sub-module jtag_tap, exporting state decode strobes (capture/shift/update for IR and DR) and the committed IR.

Verification
REQ-042 Reset, then 5 tms=1, IR=0x01, shift 32 DR bits -> tdo stream = IDCODE (0x00000001) LSB-first.
REQ-043 IR=0x10, shift DR -> 0x00001071 read back.
REQ-044 DMI write addr=0x04 data=0xDEADBEEF op=2 -> one dmi_valid pulse sequence with write=1, addr=0x04, wdata=0xDEADBEEF held until dmi_ready. Then op=1 read, responder returns 0xDEADBEEF -> next capture shows data=0xDEADBEEF, op=0.
REQ-045 Responder holds dmi_ready=0 while a second Update-DR occurs -> status=3, no second request. Then DTMCS dmireset=1 -> status 0, next op accepted.
REQ-046 resetn pulsed while dmi_valid=1 -> dmi_valid=0 next clk, TAP in Test-Logic-Reset, IR=0x01.
